// File: rtl/cellrv32_cpu_cp_shift_arbiter_if.sv
// Requester and shifter-side signal bundle of the shared shifter arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding CPU and shifter.
interface cellrv32_cpu_cp_shift_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
);
    localparam int SH_W = $clog2(XLEN);

    logic                      abort_i;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*XLEN-1:0]   req_rs1_i;
    logic [NUM_REQ*SH_W-1:0]   req_shamt_i;
    logic [NUM_REQ-1:0]        req_left_i;
    logic [NUM_REQ-1:0]        req_arith_i;
    logic [NUM_REQ-1:0]        ack_o;
    logic [XLEN-1:0]           res_o;
    logic                      err_o;
    logic                      busy_o;
    logic                      shf_start_o;
    logic [XLEN-1:0]           shf_rs1_o;
    logic [SH_W-1:0]           shf_shamt_o;
    logic                      shf_left_o;
    logic                      shf_arith_o;
    logic                      shf_trap_o;
    logic [XLEN-1:0]           shf_res_i;
    logic                      shf_valid_i;

    modport slave (
        input  abort_i, req_i, req_rs1_i, req_shamt_i, req_left_i, req_arith_i,
        input  shf_res_i, shf_valid_i,
        output ack_o, res_o, err_o, busy_o,
        output shf_start_o, shf_rs1_o, shf_shamt_o, shf_left_o, shf_arith_o, shf_trap_o
    );

    modport master (
        output abort_i, req_i, req_rs1_i, req_shamt_i, req_left_i, req_arith_i,
        output shf_res_i, shf_valid_i,
        input  ack_o, res_o, err_o, busy_o,
        input  shf_start_o, shf_rs1_o, shf_shamt_o, shf_left_o, shf_arith_o, shf_trap_o
    );
endinterface

// File: rtl/cellrv32_cpu_cp_shift_arbiter.sv
// Round-robin arbiter sharing one shifter co-processor between several CPU units,
// with local trap abort and a watchdog that forces an error completion.
module cellrv32_cpu_cp_shift_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 63
) (
    input logic                            clk_i,
    input logic                            rstn_i,
    cellrv32_cpu_cp_shift_arbiter_if.slave bus
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, grant, grant_inc, sel_idx, cidx;
    logic             sel_valid;
    int               cand;
    logic [XLEN-1:0]  op_rs1, result;
    logic [SH_W-1:0]  op_shamt;
    logic             op_left, op_arith, err;
    logic [7:0]       wdog, wdog_inc;
    logic             in_op, abort_op, timeout_hit;

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            cidx = IDX_W'(cand);
            if (bus.req_i[cidx]) begin
                sel_valid = 1'b1;
                sel_idx   = cidx;
            end
        end
    end

    assign grant_inc   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign in_op       = (state == S_START) || (state == S_WAIT) || (state == S_CAPTURE);
    assign abort_op    = in_op && bus.abort_i;
    assign wdog_inc    = wdog + 8'd1;
    assign timeout_hit = (wdog_inc == 8'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (sel_valid) state_nxt = S_START;
            S_START: begin
                if (bus.abort_i)          state_nxt = S_IDLE;
                else if (bus.shf_valid_i) state_nxt = S_CAPTURE;
                else                      state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.abort_i)          state_nxt = S_IDLE;
                else if (bus.shf_valid_i) state_nxt = S_CAPTURE;
                else if (timeout_hit)     state_nxt = S_DONE;
            end
            S_CAPTURE: state_nxt = bus.abort_i ? S_IDLE : S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Operands are latched once at grant so the serial shifter sees them frozen until IDLE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr      <= '0;
            grant    <= '0;
            op_rs1   <= '0;
            op_shamt <= '0;
            op_left  <= 1'b0;
            op_arith <= 1'b0;
            wdog     <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        grant    <= sel_idx;
                        op_rs1   <= bus.req_rs1_i[sel_idx*XLEN +: XLEN];
                        op_shamt <= bus.req_shamt_i[sel_idx*SH_W +: SH_W];
                        op_left  <= bus.req_left_i[sel_idx];
                        op_arith <= bus.req_arith_i[sel_idx];
                    end
                end
                S_START: wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog_inc;
                    if (!bus.abort_i && !bus.shf_valid_i && timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result <= bus.shf_res_i;
                    err    <= 1'b0;
                end
                S_DONE:  ptr <= grant_inc;
                default: ;
            endcase
            if (abort_op) begin
                ptr <= grant_inc;
            end
        end
    end

    // Completion data is gated to zero outside DONE so requesters never see stale results.
    always_comb begin
        bus.ack_o = '0;
        bus.res_o = '0;
        bus.err_o = 1'b0;
        if (state == S_DONE) begin
            bus.ack_o[grant] = 1'b1;
            bus.res_o        = result;
            bus.err_o        = err;
        end
    end

    assign bus.busy_o      = (state != S_IDLE);
    assign bus.shf_start_o = (state == S_START);
    assign bus.shf_rs1_o   = op_rs1;
    assign bus.shf_shamt_o = op_shamt;
    assign bus.shf_left_o  = op_left;
    assign bus.shf_arith_o = op_arith;
    assign bus.shf_trap_o  = abort_op;

endmodule
